// File: rtl/div32_seq.sv
// Sequential restoring divider for MIPS DIV/DIVU: one WIDTH+1-bit subtract per
// cycle for WIDTH cycles, then a sign fix-up cycle. Quotient feeds LO, remainder feeds HI.
module div32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_acc, rem_acc, dmag;
  logic [CNT_W-1:0] cnt;
  logic             sign_q, sign_r;
  logic [WIDTH:0]   trial;
  logic             accept;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  assign accept = start && (state == IDLE || state == DONE);
  // rem_acc < dmag always holds, so the top bit of trial is exactly the borrow.
  assign trial  = {rem_acc, q_acc[WIDTH-1]} - {1'b0, dmag};
  assign busy   = (state == CALC) || (state == FIX);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (start)              state_nx = (divisor == '0) ? DONE : CALC;
        else if (state == DONE) state_nx = IDLE;
      end
      CALC:    if (cnt == LAST) state_nx = FIX;
      FIX:     state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_acc     <= '0;
      rem_acc   <= '0;
      dmag      <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      if (divisor == '0) begin
        div_zero  <= 1'b1;
        quotient  <= '1;
        remainder <= dividend;
      end else begin
        sign_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        sign_r   <= is_signed & dividend[WIDTH-1];
        q_acc    <= mag(dividend, is_signed);
        dmag     <= mag(divisor, is_signed);
        rem_acc  <= '0;
        cnt      <= '0;
        div_zero <= 1'b0;
      end
    end else begin
      case (state)
        CALC: begin
          if (!trial[WIDTH]) rem_acc <= trial[WIDTH-1:0];
          else               rem_acc <= {rem_acc[WIDTH-2:0], q_acc[WIDTH-1]};
          q_acc <= {q_acc[WIDTH-2:0], ~trial[WIDTH]};
          cnt   <= cnt + 1'b1;
        end
        FIX: begin
          quotient  <= sign_q ? -q_acc : q_acc;
          remainder <= sign_r ? -rem_acc : rem_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Bench for div32_seq: directed MIPS corner cases plus random operands checked
// against a 64-bit arithmetic reference model.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rst, start, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q, exp_r;
  logic        exp_dz;

  div32_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit truncating division gives MIPS results, including -2^31/-1.
  task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) begin
      exp_q = 32'hFFFF_FFFF; exp_r = a; exp_dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      exp_q = 32'(sa / sb); exp_r = 32'(sa % sb); exp_dz = 1'b0;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_dz = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Called just after an edge; n edges already counted since the sampling edge.
  task automatic wait_done(input int n0, output int n, output int nb);
    n = n0; nb = 0;
    while (!done && n < 60) begin
      if (busy) nb++;
      tick(); n++;
    end
  endtask

  // Issue one op from IDLE/DONE and check it; returns in the done cycle.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n, nb;
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    tick(); start = 1'b0;
    wait_done(1, n, nb);
    ref_div(s, a, b);
    check({tag, "_lat"}, n, (b == 0) ? 32'd1 : 32'd34);
    check({tag, "_busy"}, nb, (b == 0) ? 32'd0 : 32'd33);
    check({tag, "_q"}, quotient, exp_q);
    check({tag, "_r"}, remainder, exp_r);
    check({tag, "_dz"}, {31'd0, div_zero}, {31'd0, exp_dz});
  endtask

  task automatic go_idle();
    tick();
    check("done_drop", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n, nb, dn;
    logic [31:0] held_q, a, b;
    logic s;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    tick();

    do_op(1'b0, 32'd100, 32'd7, "divu_100_7");
    check("divu_100_7_q_const", quotient, 32'd14);
    check("divu_100_7_r_const", remainder, 32'd2);
    go_idle();
    do_op(1'b1, -32'sd7, 32'd2, "div_m7_2");
    check("div_m7_2_q_const", quotient, 32'hFFFF_FFFD);
    check("div_m7_2_r_const", remainder, 32'hFFFF_FFFF);
    go_idle();
    do_op(1'b1, 32'd7, -32'sd2, "div_7_m2");
    go_idle();
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_q_const", quotient, 32'h8000_0000);
    go_idle();
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    go_idle();
    do_op(1'b0, 32'h0000_1234, 32'd0, "div_by_zero");
    check("div_by_zero_q_const", quotient, 32'hFFFF_FFFF);
    go_idle();
    do_op(1'b1, 32'd50, 32'd0, "sdiv_by_zero");
    go_idle();

    // start while busy is ignored and outputs hold during CALC
    held_q = quotient;
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    tick(); start = 1'b0;
    repeat (9) tick();
    is_signed = 1'b1; dividend = 32'd55; divisor = 32'd5; start = 1'b1;
    tick(); start = 1'b0;
    check("busy_hold_q", quotient, held_q);
    wait_done(11, n, nb);
    check("ign_lat", n, 32'd34);
    check("ign_q", quotient, 32'd14);
    check("ign_r", remainder, 32'd2);
    // back-to-back: start in the done cycle
    do_op(1'b0, 32'd1000, 32'd33, "b2b");
    go_idle();

    // reset mid-CALC abandons the op
    is_signed = 1'b0; dividend = 32'h1234_5678; divisor = 32'h11; start = 1'b1;
    tick(); start = 1'b0;
    repeat (14) tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_q", quotient, 32'd0);
    check("mid_rst_r", remainder, 32'd0);
    dn = 0;
    repeat (40) begin if (done) dn++; tick(); end
    check("mid_rst_no_done", dn, 32'd0);
    do_op(1'b0, 32'd9, 32'd3, "after_rst_9_3");
    go_idle();

    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      do_op(s, a, b, "rand");
      if (i % 3 != 0) go_idle();
    end
    go_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
